rv_multicycle_ctrl: RTL and testbench

RV_MULTICYCLE_CTRL -- requirements
Module: rv_multicycle_ctrl

---
 rtl/rv_ctrl_pkg.sv | 58 +++++
 rtl/rv_ctrl_wait_timer.sv | 37 +++
 rtl/rv_multicycle_ctrl.sv | 162 ++++++++++++++++
 tb/tb_rv_multicycle_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_ctrl_pkg.sv
// Shared control encodings for the multicycle RV32I core: opcodes, FSM states,
// PC and writeback mux selects. Also used by the instruction decoder.
package rv_ctrl_pkg;

    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_JAL      = 7'b1101111;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_BTYPE    = 7'b1100011;
    localparam logic [6:0] OP_LOADS    = 7'b0000011;
    localparam logic [6:0] OP_STORES   = 7'b0100011;
    localparam logic [6:0] OP_ARITHM_I = 7'b0010011;
    localparam logic [6:0] OP_ARITHM_R = 7'b0110011;

    typedef enum logic [2:0] {
        ST_FETCH   = 3'd0,
        ST_DECODE  = 3'd1,
        ST_EXECUTE = 3'd2,
        ST_MEM     = 3'd3,
        ST_WB      = 3'd4,
        ST_TRAP    = 3'd5
    } ctrl_state_e;

    localparam logic [1:0] PC_SEL_PLUS4  = 2'b00;
    localparam logic [1:0] PC_SEL_BRANCH = 2'b01;
    localparam logic [1:0] PC_SEL_JALR   = 2'b10;

    localparam logic [1:0] WB_SEL_ALU  = 2'b00;
    localparam logic [1:0] WB_SEL_LOAD = 2'b01;
    localparam logic [1:0] WB_SEL_PC4  = 2'b10;
    localparam logic [1:0] WB_SEL_IMM  = 2'b11;

    function automatic logic is_legal_opcode(input logic [6:0] op);
        case (op)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BTYPE,
            OP_LOADS, OP_STORES, OP_ARITHM_I, OP_ARITHM_R: is_legal_opcode = 1'b1;
            default:                                       is_legal_opcode = 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] pc_sel_of(input logic [6:0] op);
        case (op)
            OP_JAL:  pc_sel_of = PC_SEL_BRANCH;
            OP_JALR: pc_sel_of = PC_SEL_JALR;
            default: pc_sel_of = PC_SEL_PLUS4;
        endcase
    endfunction

    function automatic logic [1:0] wb_sel_of(input logic [6:0] op);
        case (op)
            OP_LOADS:         wb_sel_of = WB_SEL_LOAD;
            OP_JAL, OP_JALR:  wb_sel_of = WB_SEL_PC4;
            OP_LUI:           wb_sel_of = WB_SEL_IMM;
            default:          wb_sel_of = WB_SEL_ALU;
        endcase
    endfunction

endpackage

// File: rtl/rv_ctrl_wait_timer.sv
// Counts consecutive not-ready cycles while the controller waits on memory and
// flags expiry on the cycle the count would reach TIMEOUT_CYCLES.
module rv_ctrl_wait_timer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic waiting,
    input  logic ready,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;

    // A ready on the final cycle masks expiry, so ready always wins the race.
    always_comb begin
        cnt_inc = cnt_q + CW'(1);
        expired = waiting && !ready && (cnt_inc == CW'(TIMEOUT_CYCLES));
        cnt_d   = cnt_q;
        if (clear || !waiting) begin
            cnt_d = '0;
        end else if (!ready) begin
            cnt_d = cnt_inc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// Multicycle RV32I control FSM sequencing fetch, decode, execute, memory and writeback
// with memory-ready timeouts. Define CTRL_PERF_CNT_EN to add CYCLE_CNT/INSTRET_CNT outputs.
module rv_multicycle_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 32
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [6:0]       OPCODE,
    input  logic [4:0]       RD,
    input  logic             BR_TAKEN,
    input  logic             IMEM_READY,
    input  logic             DMEM_READY,
    output logic             IMEM_RE,
    output logic             IR_WE,
    output logic             DMEM_RE,
    output logic             DMEM_WE,
    output logic             REG_WE,
    output logic             PC_WE,
    output logic             TRAP,
    output logic [1:0]       PC_SEL,
    output logic [1:0]       WB_SEL,
    output logic [2:0]       STATE
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] CYCLE_CNT,
    output logic [CNT_W-1:0] INSTRET_CNT
`endif
);
    ctrl_state_e state_q, state_d;
    logic        wait_active, wait_ready, wait_expired, state_change;
    logic        is_load, is_store;

    assign is_load      = (OPCODE == OP_LOADS);
    assign is_store     = (OPCODE == OP_STORES);
    assign state_change = (state_d != state_q);
    assign STATE        = state_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    rv_ctrl_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk     (CLK),
        .rst_n   (RST_N),
        .clear   (state_change),
        .waiting (wait_active),
        .ready   (wait_ready),
        .expired (wait_expired)
    );

    // Outputs are gated by RST_N so enables drop the instant reset asserts.
    always_comb begin
        state_d     = state_q;
        IMEM_RE     = 1'b0;
        IR_WE       = 1'b0;
        DMEM_RE     = 1'b0;
        DMEM_WE     = 1'b0;
        REG_WE      = 1'b0;
        PC_WE       = 1'b0;
        TRAP        = 1'b0;
        PC_SEL      = PC_SEL_PLUS4;
        WB_SEL      = WB_SEL_ALU;
        wait_active = 1'b0;
        wait_ready  = 1'b0;
        if (RST_N) begin
            case (state_q)
                ST_FETCH: begin
                    IMEM_RE     = 1'b1;
                    wait_active = 1'b1;
                    wait_ready  = IMEM_READY;
                    if (IMEM_READY) begin
                        IR_WE   = 1'b1;
                        state_d = ST_DECODE;
                    end else if (wait_expired) begin
                        state_d = ST_TRAP;
                    end
                end
                ST_DECODE: begin
                    state_d = is_legal_opcode(OPCODE) ? ST_EXECUTE : ST_TRAP;
                end
                ST_EXECUTE: begin
                    if (is_load || is_store) begin
                        state_d = ST_MEM;
                    end else if (OPCODE == OP_BTYPE) begin
                        PC_WE   = 1'b1;
                        PC_SEL  = BR_TAKEN ? PC_SEL_BRANCH : PC_SEL_PLUS4;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end
                ST_MEM: begin
                    DMEM_RE     = is_load;
                    DMEM_WE     = is_store && !is_load;
                    wait_active = 1'b1;
                    wait_ready  = DMEM_READY;
                    if (DMEM_READY) begin
                        if (is_load) begin
                            state_d = ST_WB;
                        end else begin
                            PC_WE   = 1'b1;
                            state_d = ST_FETCH;
                        end
                    end else if (wait_expired) begin
                        state_d = ST_TRAP;
                    end
                end
                ST_WB: begin
                    REG_WE  = (RD != 5'd0);
                    PC_WE   = 1'b1;
                    PC_SEL  = pc_sel_of(OPCODE);
                    WB_SEL  = wb_sel_of(OPCODE);
                    state_d = ST_FETCH;
                end
                ST_TRAP: begin
                    TRAP = 1'b1;
                end
                default: begin
                    state_d = ST_TRAP;
                end
            endcase
        end
    end

`ifdef CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d, instret_cnt_q, instret_cnt_d;

    always_comb begin
        cycle_cnt_d   = cycle_cnt_q;
        instret_cnt_d = instret_cnt_q;
        if (state_q != ST_TRAP) begin
            cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
            if (PC_WE) begin
                instret_cnt_d = instret_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cycle_cnt_q   <= '0;
            instret_cnt_q <= '0;
        end else begin
            cycle_cnt_q   <= cycle_cnt_d;
            instret_cnt_q <= instret_cnt_d;
        end
    end

    assign CYCLE_CNT   = cycle_cnt_q;
    assign INSTRET_CNT = instret_cnt_q;
`endif

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Directed bench for rv_multicycle_ctrl: each instruction is expanded into its expected
// per-cycle output trace, then compared against the DUT every cycle.
`timescale 1ns/1ps
module tb_rv_multicycle_ctrl;

    localparam logic [2:0] S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
                           S_MEM = 3'd3, S_WB = 3'd4, S_TRAP = 3'd5;
    localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111,
                           OP_JALR = 7'b1100111, OP_BR = 7'b1100011, OP_LOAD = 7'b0000011,
                           OP_STORE = 7'b0100011, OP_OPI = 7'b0010011, OP_OPR = 7'b0110011;
    localparam logic [31:0] I_ADDI = 32'h00500093, I_BEQ = 32'h00000463, I_LW = 32'h0000A103,
                            I_SW = 32'h0020A023, I_JAL = 32'h008000EF, I_RET = 32'h00008067,
                            I_LUI = 32'h123452B7, I_AUIPC = 32'h00000517, I_ADD = 32'h002081B3,
                            I_BAD = 32'h0000007F;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic [6:0] OPCODE = '0;
    logic [4:0] RD = '0;
    logic       BR_TAKEN = 1'b0, IMEM_READY = 1'b0, DMEM_READY = 1'b0;
    logic       IMEM_RE, IR_WE, DMEM_RE, DMEM_WE, REG_WE, PC_WE, TRAP;
    logic [1:0] PC_SEL, WB_SEL;
    logic [2:0] STATE;
`ifdef CTRL_PERF_CNT_EN
    logic [31:0] CYCLE_CNT, INSTRET_CNT;
`endif

    rv_multicycle_ctrl #(.TIMEOUT_CYCLES(16), .CNT_W(32)) dut (
        .CLK(CLK), .RST_N(RST_N), .OPCODE(OPCODE), .RD(RD), .BR_TAKEN(BR_TAKEN),
        .IMEM_READY(IMEM_READY), .DMEM_READY(DMEM_READY), .IMEM_RE(IMEM_RE), .IR_WE(IR_WE),
        .DMEM_RE(DMEM_RE), .DMEM_WE(DMEM_WE), .REG_WE(REG_WE), .PC_WE(PC_WE), .TRAP(TRAP),
        .PC_SEL(PC_SEL), .WB_SEL(WB_SEL), .STATE(STATE)
`ifdef CTRL_PERF_CNT_EN
        , .CYCLE_CNT(CYCLE_CNT), .INSTRET_CNT(INSTRET_CNT)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [2:0] st;
        logic imem_re, ir_we, dmem_re, dmem_we, reg_we, pc_we;
        logic [1:0] pc_sel, wb_sel;
        logic trap;
    } outv_t;
    typedef struct packed {
        logic imem_ready, dmem_ready, br_taken;
        logic [6:0] op;
        logic [4:0] rd;
    } stim_t;

    outv_t act_v;
    assign act_v = {STATE, IMEM_RE, IR_WE, DMEM_RE, DMEM_WE, REG_WE, PC_WE, PC_SEL, WB_SEL, TRAP};

    stim_t stim_q[$];
    outv_t exp_q[$];
    int total = 0, bad = 0;
    int unsigned m_cyc = 0, m_ret = 0;
    int t_reg, t_pc, t_dre, t_fetch, t_cyc;
    logic [1:0] t_pcsel, t_wbsel;
    logic t_trap;
    logic [2:0] t_hist[8];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic outv_t idle(input logic [2:0] st);
        outv_t e;
        e = '0;
        e.st = st;
        return e;
    endfunction

    function automatic logic legal(input logic [6:0] op);
        return op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BR, OP_LOAD, OP_STORE, OP_OPI, OP_OPR};
    endfunction

    task automatic push(input stim_t s, input outv_t e);
        stim_q.push_back(s);
        exp_q.push_back(e);
    endtask

    // iw: not-ready fetch cycles before IMEM_READY; dw: MEM cycles incl. the ready one
    // (dw<=0 leaves the access hanging after two MEM cycles). Ready lines are toggled
    // high in non-waiting states to show they are ignored there.
    task automatic add_instr(input logic [31:0] instr, input int iw, input int dw, input logic br);
        stim_t s;
        outv_t e;
        logic [6:0] op;
        logic [4:0] rd;
        op = instr[6:0];
        rd = instr[11:7];
        s = '0;
        s.op = op; s.rd = rd; s.br_taken = br;
        e = idle(S_FETCH); e.imem_re = 1'b1;
        for (int i = 0; i < iw; i++) push(s, e);
        s.imem_ready = 1'b1; e.ir_we = 1'b1;
        push(s, e);
        s.dmem_ready = 1'b1;
        push(s, idle(S_DECODE));
        if (!legal(op)) return;
        e = idle(S_EXEC);
        if (op == OP_BR) begin
            e.pc_we = 1'b1;
            e.pc_sel = br ? 2'b01 : 2'b00;
            push(s, e);
            return;
        end
        push(s, e);
        if (op == OP_LOAD || op == OP_STORE) begin
            s.imem_ready = 1'b0; s.dmem_ready = 1'b0;
            e = idle(S_MEM);
            e.dmem_re = (op == OP_LOAD);
            e.dmem_we = (op == OP_STORE);
            if (dw <= 0) begin
                push(s, e); push(s, e);
                return;
            end
            for (int j = 0; j < dw - 1; j++) push(s, e);
            s.dmem_ready = 1'b1;
            if (op == OP_STORE) begin
                e.pc_we = 1'b1;
                push(s, e);
                return;
            end
            push(s, e);
            s.imem_ready = 1'b1;
        end
        e = idle(S_WB);
        e.reg_we = (rd != 5'd0);
        e.pc_we = 1'b1;
        e.pc_sel = (op == OP_JAL) ? 2'b01 : (op == OP_JALR) ? 2'b10 : 2'b00;
        e.wb_sel = (op == OP_LOAD) ? 2'b01 : (op == OP_JAL || op == OP_JALR) ? 2'b10 :
                   (op == OP_LUI) ? 2'b11 : 2'b00;
        push(s, e);
    endtask

    task automatic add_trap(input int n);
        stim_t s;
        outv_t e;
        s = '0; s.op = 7'h7F;
        e = idle(S_TRAP); e.trap = 1'b1;
        for (int i = 0; i < n; i++) begin
            s.imem_ready = i[0];
            s.dmem_ready = ~i[0];
            push(s, e);
        end
    endtask

    task automatic add_timeout();
        stim_t s;
        outv_t e;
        s = '0; s.op = OP_OPI;
        e = idle(S_FETCH); e.imem_re = 1'b1;
        for (int i = 0; i < 16; i++) push(s, e);
        add_trap(4);
    endtask

    task automatic clr_tally();
        t_reg = 0; t_pc = 0; t_dre = 0; t_fetch = 0; t_cyc = 0;
        t_pcsel = 2'b11; t_wbsel = 2'b11; t_trap = 1'b0;
        for (int i = 0; i < 8; i++) t_hist[i] = 3'd7;
    endtask

    task automatic run_queue();
        stim_t s;
        outv_t e;
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            e = exp_q.pop_front();
            IMEM_READY = s.imem_ready; DMEM_READY = s.dmem_ready; BR_TAKEN = s.br_taken;
            OPCODE = s.op; RD = s.rd;
            @(negedge CLK);
            check("cycle_outputs", 32'(act_v), 32'(e));
`ifdef CTRL_PERF_CNT_EN
            check("cycle_cnt", CYCLE_CNT, m_cyc);
            check("instret_cnt", INSTRET_CNT, m_ret);
`endif
            if (e.st != S_TRAP) m_cyc++;
            if (e.pc_we) m_ret++;
            if (t_cyc < 8) t_hist[t_cyc] = STATE;
            if (REG_WE) begin t_reg++; t_wbsel = WB_SEL; end
            if (PC_WE) begin t_pc++; t_pcsel = PC_SEL; end
            if (DMEM_RE) t_dre++;
            if (STATE == S_FETCH) t_fetch++;
            if (TRAP) t_trap = 1'b1;
            t_cyc++;
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST_N = 1'b0;
        #1;
        check("reset_outputs", 32'(act_v), 32'(idle(S_FETCH)));
`ifdef CTRL_PERF_CNT_EN
        check("reset_cycle_cnt", CYCLE_CNT, 0);
        check("reset_instret_cnt", INSTRET_CNT, 0);
`endif
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        m_cyc = 0; m_ret = 0;
    endtask

    task automatic txn(input string nm, input logic [31:0] instr, input int iw, input int dw,
                       input logic br);
        clr_tally();
        add_instr(instr, iw, dw, br);
        run_queue();
        $display("txn %s: cycles=%0d pc_we=%0d reg_we=%0d", nm, t_cyc, t_pc, t_reg);
    endtask

    initial begin
        logic [2:0] addi_hist[5];
        addi_hist[0] = S_FETCH; addi_hist[1] = S_FETCH; addi_hist[2] = S_DECODE;
        addi_hist[3] = S_EXEC;  addi_hist[4] = S_WB;

        do_reset();

        txn("addi", I_ADDI, 1, 0, 1'b0);
        for (int i = 0; i < 5; i++)
            check($sformatf("addi_state%0d", i), 32'(t_hist[i]), 32'(addi_hist[i]));
        check("addi_reg_we_count", t_reg, 1);
        check("addi_pc_we_count", t_pc, 1);
        check("addi_pc_sel", 32'(t_pcsel), 32'h0);

        txn("beq_taken", I_BEQ, 1, 0, 1'b1);
        check("beq_pc_sel", 32'(t_pcsel), 32'h1);
        check("beq_reg_we_count", t_reg, 0);
        check("beq_pc_we_count", t_pc, 1);
        check("beq_exec_4th", 32'(t_hist[3]), 32'(S_EXEC));
        check("beq_back_fetch", 32'(STATE), 32'(S_FETCH));

        txn("beq_not_taken", I_BEQ, 0, 0, 1'b0);
        check("beq_nt_pc_sel", 32'(t_pcsel), 32'h0);

        txn("lw", I_LW, 0, 3, 1'b0);
        check("lw_dmem_re_cycles", t_dre, 3);
        check("lw_wb_sel", 32'(t_wbsel), 32'h1);
        check("lw_reg_we_count", t_reg, 1);

        txn("sw", I_SW, 0, 2, 1'b0);
        check("sw_reg_we_count", t_reg, 0);
        check("sw_pc_we_count", t_pc, 1);

        txn("jal", I_JAL, 0, 0, 1'b0);
        check("jal_pc_sel", 32'(t_pcsel), 32'h1);
        check("jal_wb_sel", 32'(t_wbsel), 32'h2);
        txn("jalr_x0", I_RET, 0, 0, 1'b0);
        check("jalr_pc_sel", 32'(t_pcsel), 32'h2);
        check("jalr_no_reg_we", t_reg, 0);
        txn("lui", I_LUI, 0, 0, 1'b0);
        check("lui_wb_sel", 32'(t_wbsel), 32'h3);
        txn("auipc", I_AUIPC, 2, 0, 1'b0);
        txn("add", I_ADD, 0, 0, 1'b0);
        txn("fetch_ready_16th", I_ADDI, 15, 0, 1'b0);
        check("fetch16_no_trap", 32'(t_trap), 32'h0);
        txn("lw_ready_16th", I_LW, 0, 16, 1'b0);
        check("mem16_dmem_re_cycles", t_dre, 16);

        do_reset();
        clr_tally();
        for (int i = 0; i < 3; i++) add_instr(I_ADDI, 0, 0, 1'b0);
        run_queue();
        $display("txn three_addi: cycles=%0d pc_we=%0d", t_cyc, t_pc);
`ifdef CTRL_PERF_CNT_EN
        check("instret_after_3_addi", INSTRET_CNT, 3);
`endif
        check("three_addi_pc_we", t_pc, 3);

        clr_tally();
        add_instr(I_BAD, 1, 0, 1'b0);
        add_trap(6);
        run_queue();
        $display("txn illegal: cycles=%0d trap=%0b", t_cyc, t_trap);
        check("illegal_trap_held", 32'(TRAP), 32'h1);
        check("illegal_trap_after_decode", 32'(t_hist[3]), 32'(S_TRAP));
        do_reset();

        clr_tally();
        add_timeout();
        run_queue();
        $display("txn fetch_timeout: cycles=%0d fetch=%0d", t_cyc, t_fetch);
        check("timeout_fetch_cycles", t_fetch, 16);
        do_reset();

        clr_tally();
        add_instr(I_SW, 0, 0, 1'b0);
        run_queue();
        check("sw_hang_dmem_we", 32'(DMEM_WE), 32'h1);
        #2;
        RST_N = 1'b0;
        #1;
        check("midmem_rst_dmem_we", 32'(DMEM_WE), 32'h0);
        check("midmem_rst_state", 32'(STATE), 32'(S_FETCH));
        $display("txn sw_reset_mid_mem: cycles=%0d", t_cyc);
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        m_cyc = 0; m_ret = 0;
        txn("addi_after_reset", I_ADDI, 0, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
